// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two per-source FIFOs (ALU, load unit) feeding the single
// register-file write port round-robin, with a pending-write hazard mask.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            RegWrite,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] Write_data,
    output logic [31:0]     pend_mask,
    output logic            busy
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned NSRC = 2;

    typedef enum logic {G_ALU = 1'b0, G_MEM = 1'b1} grant_e;

    logic [NSRC-1:0] in_valid;
    logic [4:0]      in_rd   [NSRC];
    logic [XLEN-1:0] in_data [NSRC];

    logic [4:0]      rd_mem   [NSRC][DEPTH];
    logic [XLEN-1:0] data_mem [NSRC][DEPTH];

    logic [PW-1:0] wptr_q  [NSRC];
    logic [PW-1:0] wptr_d  [NSRC];
    logic [PW-1:0] rptr_q  [NSRC];
    logic [PW-1:0] rptr_d  [NSRC];
    logic [CW-1:0] count_q [NSRC];
    logic [CW-1:0] count_d [NSRC];

    grant_e          last_grant_q, last_grant_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [NSRC-1:0] ready, push, pop, nonempty;

    // Index 0 is the ALU, index 1 the load unit.
    assign in_valid   = {mem_valid, alu_valid};
    assign in_rd[0]   = alu_rd;
    assign in_rd[1]   = mem_rd;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;

    // Handshake, round-robin grant and next-state for pointers/outputs.
    always_comb begin
        ready        = '0;
        push         = '0;
        pop          = '0;
        nonempty     = '0;
        last_grant_d = last_grant_q;
        regwrite_d   = 1'b0;
        rd_d         = rd_q;
        wdata_d      = wdata_q;
        for (int s = 0; s < NSRC; s++) begin
            ready[s]    = count_q[s] < CW'(DEPTH);
            push[s]     = in_valid[s] & ready[s] & (in_rd[s] != 5'd0);
            nonempty[s] = count_q[s] != '0;
        end
        if (nonempty[0] && (!nonempty[1] || last_grant_q == G_MEM)) begin
            pop[0]       = 1'b1;
            last_grant_d = G_ALU;
        end else if (nonempty[1]) begin
            pop[1]       = 1'b1;
            last_grant_d = G_MEM;
        end
        for (int s = 0; s < NSRC; s++) begin
            if (pop[s]) begin
                regwrite_d = 1'b1;
                rd_d       = rd_mem[s][rptr_q[s]];
                wdata_d    = data_mem[s][rptr_q[s]];
            end
            wptr_d[s]  = wptr_q[s] + PW'(push[s]);
            rptr_d[s]  = rptr_q[s] + PW'(pop[s]);
            count_d[s] = count_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
    end

    // Hazard mask: every live FIFO entry plus the write currently on the port.
    always_comb begin
        pend_mask = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < count_q[s]) begin
                    pend_mask[rd_mem[s][rptr_q[s] + PW'(i)]] = 1'b1;
                end
            end
        end
        if (regwrite_q) begin
            pend_mask[rd_q] = 1'b1;
        end
    end

    // Payload storage needs no reset; validity comes from the counts.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                rd_mem[s][wptr_q[s]]   <= in_rd[s];
                data_mem[s][wptr_q[s]] <= in_data[s];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSRC; s++) begin
                wptr_q[s]  <= '0;
                rptr_q[s]  <= '0;
                count_q[s] <= '0;
            end
            last_grant_q <= G_MEM;
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                wptr_q[s]  <= wptr_d[s];
                rptr_q[s]  <= rptr_d[s];
                count_q[s] <= count_d[s];
            end
            last_grant_q <= last_grant_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
        end
    end

    assign alu_ready  = ready[0];
    assign mem_ready  = ready[1];
    assign RegWrite   = regwrite_q;
    assign Rd         = rd_q;
    assign Write_data = wdata_q;
    assign busy       = (|nonempty) | regwrite_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: constant vector table, directed corner sequences
// and random traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]      alu_rd, mem_rd, Rd;
    logic [XLEN-1:0] alu_data, mem_data, Write_data;
    logic            RegWrite, busy;
    logic [31:0]     pend_mask;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
        .pend_mask(pend_mask), .busy(busy)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic mv; logic [4:0] mrd; logic [31:0] md;
        logic rw; logic [4:0] rd; logic [31:0] wd; logic [31:0] pend; logic busy;
    } vec_t;

    // Reference model: per-source queues, who won last, and the write port.
    wr_t         aq[$];
    wr_t         mq[$];
    bit          last_alu;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    int n_checks = 0;
    int n_errors = 0;

    wr_t seen[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        foreach (aq[i]) p[aq[i].rd] = 1'b1;
        foreach (mq[i]) p[mq[i].rd] = 1'b1;
        if (m_rw) p[m_rd] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        aq.delete();
        mq.delete();
        last_alu = 1'b0;
        m_rw     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
    endtask

    // One clock: drive, check readies, clock, advance model, check outputs.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         output logic a_acc, output logic m_acc);
        bit  a_ok, m_ok;
        int  take;
        wr_t w;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        a_ok = aq.size() < DEPTH;
        m_ok = mq.size() < DEPTH;
        check("alu_ready", alu_ready, a_ok);
        check("mem_ready", mem_ready, m_ok);
        a_acc = av && a_ok;
        m_acc = mv && m_ok;
        @(posedge clk);
        #1;
        if (aq.size() > 0 && mq.size() > 0) take = last_alu ? 2 : 1;
        else if (aq.size() > 0)             take = 1;
        else if (mq.size() > 0)             take = 2;
        else                                take = 0;
        if (take == 1) begin
            w = aq.pop_front(); last_alu = 1'b1;
        end else if (take == 2) begin
            w = mq.pop_front(); last_alu = 1'b0;
        end
        if (take != 0) begin
            m_rw = 1'b1; m_rd = w.rd; m_data = w.data;
        end else begin
            m_rw = 1'b0;
        end
        if (a_acc && ard != 5'd0) aq.push_back('{rd: ard, data: ad});
        if (m_acc && mrd != 5'd0) mq.push_back('{rd: mrd, data: md});
        check("RegWrite",   RegWrite,   m_rw);
        check("Rd",         Rd,         m_rd);
        check("Write_data", Write_data, m_data);
        check("pend_mask",  pend_mask,  model_pend());
        check("busy",       busy,       (aq.size() > 0) || (mq.size() > 0) || m_rw);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        if (RegWrite) seen.push_back('{rd: Rd, data: Write_data});
    endtask

    task automatic idle(input int n);
        logic a, m;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        seen.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[12];
        logic a, m;
        int   ai, mi, first_w, last_w, cyc, m_accs, low_seen, k, guard;
        wr_t  issued[$];
        logic [4:0] exp_seq[8];

        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_RegWrite", RegWrite, 1'b0);
        check("rst_Rd", Rd, 5'd0);
        check("rst_Write_data", Write_data, 32'd0);
        check("rst_pend_mask", pend_mask, 32'd0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_alu_ready", alu_ready, 1'b1);
        check("rst_mem_ready", mem_ready, 1'b1);

        // Single write, x0 filter, and a two-source tie after the ALU won last.
        vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,        32'h20,  1'b1};
        vt[1]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h20,  1'b1};
        vt[2]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b0};
        vt[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b0};
        vt[4]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,   1'b0};
        vt[5]  = '{1'b1, 5'd7, 32'hA7,       1'b1, 5'd9, 32'hB9, 1'b0, 5'd5, 32'hDEADBEEF, 32'h280, 1'b1};
        vt[6]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hB9,       32'h280, 1'b1};
        vt[7]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA7,       32'h80,  1'b1};
        vt[8]  = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 32'hA7,       32'h0,   1'b0};
        vt[9]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd0, 32'd1, 1'b0, 5'd7, 32'hA7,       32'h8,   1'b1};
        vt[10] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33,       32'h8,   1'b1};
        vt[11] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 32'h33,       32'h0,   1'b0};
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].av, vt[i].ard, vt[i].ad, vt[i].mv, vt[i].mrd, vt[i].md, a, m);
            check($sformatf("tbl%0d_rw", i),   RegWrite,   vt[i].rw);
            check($sformatf("tbl%0d_rd", i),   Rd,         vt[i].rd);
            check($sformatf("tbl%0d_wd", i),   Write_data, vt[i].wd);
            check($sformatf("tbl%0d_pend", i), pend_mask,  vt[i].pend);
            check($sformatf("tbl%0d_busy", i), busy,       vt[i].busy);
        end

        // Contention: both sources stream four writes each from the same cycle.
        do_reset();
        exp_seq = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
        ai = 0; mi = 0; first_w = -1; last_w = -1;
        for (cyc = 0; cyc < 40 && seen.size() < 8; cyc++) begin
            cycle(ai < 4, 5'(ai + 1), 32'h100 + ai, mi < 4, 5'(mi + 11), 32'h200 + mi, a, m);
            if (a) ai++;
            if (m) mi++;
            if (RegWrite) begin
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
            end
        end
        check("cont_count", seen.size(), 8);
        check("cont_no_gap", last_w - first_w, 7);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            check($sformatf("cont_rd%0d", i), seen[i].rd, exp_seq[i]);
        idle(2);

        // Backpressure: load unit held valid for 6 cycles, ALU also backlogged.
        do_reset();
        ai = 0; mi = 0; m_accs = 0; low_seen = 0;
        issued.delete();
        for (cyc = 0; cyc < 6; cyc++) begin
            if (!mem_ready && low_seen == 0) begin
                low_seen = 1;
                check("bp_accepts_before_full", m_accs, 2);
            end
            cycle(1'b1, 5'(1 + (ai % 15)), $urandom, 1'b1, 5'(20 + mi), 32'h5000 + mi, a, m);
            if (a) ai++;
            if (m) begin
                issued.push_back('{rd: 5'(20 + mi), data: 32'h5000 + mi});
                mi++; m_accs++;
            end
        end
        check("bp_ready_dropped", low_seen, 1);
        idle(20);
        k = 0;
        foreach (seen[i]) begin
            if (seen[i].rd >= 5'd20) begin
                if (k < issued.size()) begin
                    check($sformatf("bp_rd%0d", k), seen[i].rd, issued[k].rd);
                    check($sformatf("bp_wd%0d", k), seen[i].data, issued[k].data);
                end
                k++;
            end
        end
        check("bp_mem_write_count", k, issued.size());
        check("bp_alu_write_count", seen.size() - k, ai);

        // Asynchronous reset with three writes queued and one on the port.
        do_reset();
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'h11, a, m);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'h12, a, m);
        check("rmid_pre_rw", RegWrite, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rmid_async_rw", RegWrite, 1'b0);
        check("rmid_async_pend", pend_mask, 32'd0);
        check("rmid_async_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen.delete();
        idle(3);
        check("rmid_no_stale", seen.size(), 0);
        cycle(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, a, m);
        idle(1);
        check("rmid_first_alu_rd", Rd, 5'd6);
        check("rmid_first_alu_wd", Write_data, 32'h66);
        idle(3);

        // Wrap-around: 20 ALU writes with random idle gaps.
        do_reset();
        issued.delete();
        for (k = 1; k <= 20; k++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            issued.push_back('{rd: 5'(k), data: $urandom});
            a = 1'b0;
            for (guard = 0; guard < 10 && !a; guard++)
                cycle(1'b1, 5'(k), issued[k-1].data, 1'b0, 5'd0, 32'd0, a, m);
            check($sformatf("wrap_acc%0d", k), a, 1'b1);
        end
        idle(4);
        check("wrap_count", seen.size(), 20);
        for (int i = 0; i < 20 && i < seen.size(); i++) begin
            check($sformatf("wrap_rd%0d", i), seen[i].rd, issued[i].rd);
            check($sformatf("wrap_wd%0d", i), seen[i].data, issued[i].data);
        end

        // Random traffic on both sources, including rd==0.
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, a, m);
        idle(6);
        check("rand_drained_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
